seven_seg_reader: RTL and testbench

Receive-side companion to the hex-to-segment decoder. It monitors a time-multiplexed, active-low 4-digit seven-segment bus (segment pattern plus digit anodes) and recovers the displayed 16-bit hex value, one full frame at a time. It is used for loopback self-check of the calculator display path and in benches that must read back what the ALU displayed without inspecting internal registers.

---
 rtl/seven_seg_pkg.sv | 32 +++
 rtl/seg_pattern_to_hex.sv | 34 +++
 rtl/seven_seg_reader.sv | 132 +++++++++++++
 tb/tb_seven_seg_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared glyph constants, digit count and FSM states for the seven-segment reader
package seven_seg_pkg;

    localparam int NUM_DIGITS            = 4;
    localparam int DEFAULT_STABLE_CYCLES = 4;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_HOLD
    } state_t;

endpackage

// File: rtl/seg_pattern_to_hex.sv
// rtl/seg_pattern_to_hex.sv - inverse of the hex display decoder; unknown patterns flag bad
module seg_pattern_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       bad
);

    always_comb begin
        nibble = 4'h0;
        bad    = 1'b0;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// rtl/seven_seg_reader.sv - recovers the 16-bit hex value shown on a multiplexed active-low 4-digit display
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     digit_bad,
    output logic                      frame_valid,
    output logic                      frame_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    state_t                  state, state_next;
    logic [CW-1:0]           cnt, cnt_next;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   cap_mask;
    logic [NUM_DIGITS-1:0]   seen;
    logic                    multi_err;
    logic [4*NUM_DIGITS-1:0] shadow_nib;
    logic [NUM_DIGITS-1:0]   shadow_bad;
    logic [3:0]              dec_nibble;
    logic                    dec_bad;
    logic                    one_hot, multi, same;

    // The incoming pin value is the sample being loaded this edge; the sample
    // register holds the previous one, so stability is judged edge by edge.
    assign one_hot  = $onehot(~an_in);
    assign multi    = ($countones(~an_in) > 1);
    assign same     = ({an_in, seg_in} == {an_q, seg_q});
    assign cap_mask = capture ? ~an_in : '0;

    seg_pattern_to_hex u_decode (
        .pattern (seg_q),
        .nibble  (dec_nibble),
        .bad     (dec_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        if (!one_hot) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_COUNT;
                    cnt_next   = CW'(1);
                end
                S_COUNT: begin
                    if (!same) begin
                        cnt_next = CW'(1);
                    end else begin
                        if (cnt < CW'(STABLE_CYCLES))
                            cnt_next = cnt + CW'(1);
                        if (cnt == CW'(STABLE_CYCLES - 1)) begin
                            capture    = 1'b1;
                            state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!same) begin
                        state_next = S_COUNT;
                        cnt_next   = CW'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            seen        <= '0;
            multi_err   <= 1'b0;
            shadow_nib  <= '0;
            shadow_bad  <= '0;
            value       <= '0;
            digit_bad   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            an_q        <= an_in;
            seg_q       <= seg_in;
            frame_valid <= 1'b0;
            // Publish reads the shadow before any same-edge capture lands in it
            if (&seen) begin
                value       <= shadow_nib;
                digit_bad   <= shadow_bad;
                frame_err   <= multi_err;
                frame_valid <= 1'b1;
                seen        <= cap_mask;
                multi_err   <= multi;
            end else begin
                seen        <= seen | cap_mask;
                multi_err   <= multi_err | multi;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_mask[i]) begin
                    shadow_nib[4*i +: 4] <= dec_nibble;
                    shadow_bad[i]        <= dec_bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// tb/tb_seven_seg_reader.sv - self-checking bench for seven_seg_reader
module tb_seven_seg_reader;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = 7'b1111111;
    logic [3:0]  an_in = 4'b1111;
    logic [15:0] value;
    logic [3:0]  digit_bad;
    logic        frame_valid;
    logic        frame_err;

    always #5 clk = ~clk;

    seven_seg_reader #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .value       (value),
        .digit_bad   (digit_bad),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    localparam logic [6:0] BLANK = 7'b1111111;

    int total = 0;
    int bad = 0;

    // reference model state
    int          m_run = 0;
    logic [10:0] m_run_val = '0;
    logic [3:0]  m_seen = '0;
    logic [3:0]  m_nib [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  m_bad = '0;
    logic        m_multi = 1'b0;
    logic [15:0] exp_value = '0;
    logic [3:0]  exp_bad = '0;
    logic        exp_fv = 1'b0;
    logic        exp_fe = 1'b0;

    int          pulses = 0;
    logic [15:0] last_val = '0;
    logic [3:0]  last_bad = '0;
    logic        last_fe = 1'b0;

    typedef struct {
        logic [27:0] pats;
        logic [15:0] v;
        logic [3:0]  b;
    } frame_vec_t;
    frame_vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p) return {1'b0, 4'(i)};
        return 5'b10000;
    endfunction

    task automatic model_step(input logic [3:0] an, input logic [6:0] seg, input logic r);
        logic [3:0] mask;
        logic [4:0] dec;
        logic       mul;
        if (r) begin
            m_run = 0; m_seen = '0; m_multi = 1'b0; m_bad = '0;
            for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
            exp_value = '0; exp_bad = '0; exp_fv = 1'b0; exp_fe = 1'b0;
        end else begin
            mask = '0;
            mul  = ($countones(~an) >= 2);
            if ($countones(~an) == 1) begin
                if (m_run > 0 && {an, seg} == m_run_val) m_run++;
                else begin m_run = 1; m_run_val = {an, seg}; end
                if (m_run == S) mask = ~an;
            end else begin
                m_run = 0;
            end
            exp_fv = (m_seen == 4'hF);
            if (exp_fv) begin
                exp_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                exp_bad   = m_bad;
                exp_fe    = m_multi;
                m_seen    = mask;
                m_multi   = mul;
            end else begin
                m_seen  = m_seen | mask;
                m_multi = m_multi | mul;
            end
            dec = ref_decode(seg);
            for (int i = 0; i < 4; i++)
                if (mask[i]) begin m_nib[i] = dec[3:0]; m_bad[i] = dec[4]; end
        end
    endtask

    task automatic cycle(input logic [3:0] an, input logic [6:0] seg, input logic r);
        an_in = an; seg_in = seg; rst = r;
        @(posedge clk);
        model_step(an, seg, r);
        @(negedge clk);
        check("cycle", 32'({value, digit_bad, frame_valid, frame_err}),
              32'({exp_value, exp_bad, exp_fv, exp_fe}));
        if (frame_valid) begin
            pulses++; last_val = value; last_bad = digit_bad; last_fe = frame_err;
        end
    endtask

    task automatic show(input int d, input logic [6:0] seg, input int dwell);
        repeat (dwell) cycle(~(4'b0001 << d), seg, 1'b0);
    endtask

    task automatic scan(input logic [27:0] pats, input int dwell);
        for (int d = 0; d < 4; d++) show(d, pats[7*d +: 7], dwell);
        cycle(4'b1111, BLANK, 1'b0);
        cycle(4'b1111, BLANK, 1'b0);
    endtask

    logic [27:0] p1a3f;

    initial begin
        p1a3f = {glyph[1], glyph[10], glyph[3], glyph[15]};
        tbl[0] = '{p1a3f, 16'h1A3F, 4'b0000};
        tbl[1] = '{{glyph[1], BLANK, glyph[3], glyph[15]}, 16'h103F, 4'b0100};
        tbl[2] = '{{glyph[8], glyph[9], glyph[10], glyph[11]}, 16'h89AB, 4'b0000};
        tbl[3] = '{{glyph[12], glyph[13], glyph[14], glyph[0]}, 16'hCDE0, 4'b0000};
        tbl[4] = '{{glyph[4], glyph[5], 7'b1111110, glyph[7]}, 16'h4507, 4'b0010};

        cycle(4'b1111, BLANK, 1'b1);
        cycle(4'b1111, BLANK, 1'b1);
        check("reset_outputs", 32'({value, digit_bad, frame_valid, frame_err}), 32'h0);

        for (int t = 0; t < 5; t++) begin
            pulses = 0;
            scan(tbl[t].pats, 8);
            check("tbl_pulses", 32'(pulses), 32'd1);
            check("tbl_value", 32'(last_val), 32'(tbl[t].v));
            check("tbl_bad", 32'(last_bad), 32'(tbl[t].b));
            check("tbl_err", 32'(last_fe), 32'd0);
        end

        pulses = 0;
        scan(p1a3f, 8);
        scan(p1a3f, 8);
        check("repeat_pulses", 32'(pulses), 32'd2);

        // short dwells are ignored, a dwell of exactly S is accepted
        cycle(4'b1111, BLANK, 1'b1);
        pulses = 0;
        scan(p1a3f, 3);
        scan(p1a3f, 3);
        check("dwell3_pulses", 32'(pulses), 32'd0);
        for (int d = 0; d < 4; d++) show(d, p1a3f[7*d +: 7], 4);
        cycle(4'b1111, BLANK, 1'b0);
        check("dwell4_pulse", 32'(frame_valid), 32'd1);
        check("dwell4_value", 32'(value), 32'h1A3F);

        // multi-anode glitch flags exactly one frame
        cycle(4'b1111, BLANK, 1'b1);
        pulses = 0;
        show(0, glyph[15], 8);
        show(1, glyph[3], 3);
        cycle(4'b1100, glyph[3], 1'b0);
        show(1, glyph[3], 8);
        show(2, glyph[10], 8);
        show(3, glyph[1], 8);
        cycle(4'b1111, BLANK, 1'b0);
        cycle(4'b1111, BLANK, 1'b0);
        check("multi_pulses", 32'(pulses), 32'd1);
        check("multi_err", 32'(last_fe), 32'd1);
        check("multi_value", 32'(last_val), 32'h1A3F);
        scan(p1a3f, 8);
        check("clean_err", 32'(last_fe), 32'd0);

        // reset mid-frame discards the partial frame
        show(0, glyph[15], 8);
        show(1, glyph[3], 8);
        show(2, glyph[10], 8);
        cycle(4'b1111, BLANK, 1'b1);
        check("midrst_outputs", 32'({value, digit_bad, frame_valid, frame_err}), 32'h0);
        pulses = 0;
        show(3, glyph[1], 8);
        cycle(4'b1111, BLANK, 1'b0);
        cycle(4'b1111, BLANK, 1'b0);
        check("midrst_nopub", 32'(pulses), 32'd0);
        check("midrst_value", 32'(value), 32'h0);
        scan(p1a3f, 8);
        check("midrst_recover", 32'(last_val), 32'h1A3F);

        // reverse-ish order with digit 0 overwritten before the frame completes
        pulses = 0;
        show(3, glyph[1], 8);
        show(2, glyph[10], 8);
        show(0, glyph[0], 8);
        show(0, glyph[7], 8);
        show(1, glyph[3], 8);
        cycle(4'b1111, BLANK, 1'b0);
        cycle(4'b1111, BLANK, 1'b0);
        check("overwrite_pulses", 32'(pulses), 32'd1);
        check("overwrite_value", 32'(last_val), 32'h1A37);

        // randomized traffic against the reference model
        for (int n = 0; n < 700; n++) begin
            int mode;
            int dw;
            logic [3:0] an;
            logic [6:0] sg;
            mode = $urandom_range(0, 39);
            dw   = $urandom_range(1, 7);
            if (mode == 0) begin
                cycle(4'b1111, BLANK, 1'b1);
            end else if (mode < 3) begin
                do an = 4'($urandom); while ($countones(~an) < 2);
                cycle(an, glyph[$urandom_range(0, 15)], 1'b0);
            end else if (mode < 5) begin
                repeat (dw) cycle(4'b1111, BLANK, 1'b0);
            end else begin
                sg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
                show($urandom_range(0, 3), sg, dw);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
